vdp_mac_seq_ctrl: RTL and testbench

Sequencer for the single-cycle signed MAC dot-product datapath (`mac_nnbit_1cc`, N-bit inputs, K-dim vectors). On an accepted start request it:
- clears the MAC,
- streams K element pairs from the G/E operand buffers into the MAC,
- waits out the pipeline drain,
- presents the (2N+K-1)-bit result on a valid/ready output.

It sits between the job issuer and the MAC/operand buffers, and owns MAC reset and input gating.

---
 rtl/vdp_mac_seq_ctrl.sv | 114 +++++++++++
 tb/tb_vdp_mac_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_mac_seq_ctrl.sv
// Job sequencer for a signed MAC dot-product datapath: clears the MAC, streams K
// operand pairs from the G/E buffers, waits for the pipeline to drain, then holds the result.
module vdp_mac_seq_ctrl #(
  parameter int N       = 8,
  parameter int K       = 3,
  parameter int MAC_LAT = 1,
  parameter int AW      = (K > 1) ? $clog2(K) : 1,
  localparam int RW     = 2 * N + K - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [N-1:0]         g_rdata,
  input  logic [N-1:0]         e_rdata,
  output logic                 mac_rst,
  output logic [N-1:0]         g_input,
  output logic [N-1:0]         e_input,
  input  logic [RW-1:0]        mac_o,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RW-1:0]        res_data,
  output logic                 busy
);

  localparam int DW = (MAC_LAT + 2 > 2) ? $clog2(MAC_LAT + 2) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ISSUE,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [RW-1:0]   res_q, res_d;
  logic            rd_v_q;
  logic [N-1:0]    g_q, e_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) state_d = S_CLR;
      end
      S_CLR: begin
        idx_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // idx returns to 0 on the last element so the next job starts clean
        if (idx_q == AW'(K - 1)) begin
          idx_d   = '0;
          dcnt_d  = DW'(MAC_LAT + 1);
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == '0) begin
          res_d   = mac_o;
          state_d = S_OUT;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      res_q   <= '0;
      rd_v_q  <= 1'b0;
      g_q     <= '0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      res_q   <= res_d;
      rd_v_q  <= rd_en;
      // Zero operands whenever no element is in flight keep the accumulator frozen
      g_q     <= rd_v_q ? g_rdata : '0;
      e_q     <= rd_v_q ? e_rdata : '0;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign rd_en       = (state_q == S_ISSUE);
  assign rd_addr     = idx_q;
  assign mac_rst     = rst | (state_q == S_CLR);
  assign g_input     = g_q;
  assign e_input     = e_q;
  assign res_valid   = (state_q == S_OUT);
  assign res_data    = res_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_vdp_mac_seq_ctrl.sv
// Bench for vdp_mac_seq_ctrl: default build (K=3, MAC_LAT=1) and a K=1, MAC_LAT=2 build,
// each driven against a behavioural operand buffer and MAC model.
module tb_vdp_mac_seq_ctrl;

  localparam int N    = 8;
  localparam int KA   = 3;
  localparam int LA   = 1;
  localparam int RWA  = 2 * N + KA - 1;
  localparam int KB   = 1;
  localparam int LB   = 2;
  localparam int RWB  = 2 * N + KB - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- build A ----------------
  logic                   a_start_valid = 1'b0, a_start_ready, a_rd_en, a_mac_rst;
  logic [1:0]             a_rd_addr;
  logic signed [N-1:0]    a_g_rdata, a_e_rdata, a_g_input, a_e_input;
  logic signed [RWA-1:0]  a_mac_o, a_res_data;
  logic                   a_res_valid, a_res_ready = 1'b1, a_busy;
  logic signed [N-1:0]    a_g_mem [0:3];
  logic signed [N-1:0]    a_e_mem [0:3];

  vdp_mac_seq_ctrl #(.N(N), .K(KA), .MAC_LAT(LA)) dut_a (
    .clk(clk), .rst(rst), .start_valid(a_start_valid), .start_ready(a_start_ready),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .g_rdata(a_g_rdata), .e_rdata(a_e_rdata),
    .mac_rst(a_mac_rst), .g_input(a_g_input), .e_input(a_e_input), .mac_o(a_mac_o),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_data(a_res_data), .busy(a_busy)
  );

  always_ff @(posedge clk) begin
    if (a_rd_en) begin
      a_g_rdata <= a_g_mem[a_rd_addr];
      a_e_rdata <= a_e_mem[a_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (a_mac_rst) a_mac_o <= '0;
    else           a_mac_o <= a_mac_o + a_g_input * a_e_input;
  end

  // ---------------- build B ----------------
  logic                   b_start_valid = 1'b0, b_start_ready, b_rd_en, b_mac_rst;
  logic [0:0]             b_rd_addr;
  logic signed [N-1:0]    b_g_rdata, b_e_rdata, b_g_input, b_e_input;
  logic signed [RWB-1:0]  b_acc, b_mac_o, b_res_data;
  logic                   b_res_valid, b_res_ready = 1'b1, b_busy;
  logic signed [N-1:0]    b_g_mem [0:1];
  logic signed [N-1:0]    b_e_mem [0:1];

  vdp_mac_seq_ctrl #(.N(N), .K(KB), .MAC_LAT(LB)) dut_b (
    .clk(clk), .rst(rst), .start_valid(b_start_valid), .start_ready(b_start_ready),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .g_rdata(b_g_rdata), .e_rdata(b_e_rdata),
    .mac_rst(b_mac_rst), .g_input(b_g_input), .e_input(b_e_input), .mac_o(b_mac_o),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data), .busy(b_busy)
  );

  always_ff @(posedge clk) begin
    if (b_rd_en) begin
      b_g_rdata <= b_g_mem[b_rd_addr];
      b_e_rdata <= b_e_mem[b_rd_addr];
    end
  end

  // Two-cycle MAC: accumulator followed by one output register
  always_ff @(posedge clk) begin
    if (b_mac_rst) begin
      b_acc   <= '0;
      b_mac_o <= '0;
    end else begin
      b_acc   <= b_acc + b_g_input * b_e_input;
      b_mac_o <= b_acc;
    end
  end

  // ---------------- build A job runner ----------------
  // Called at a negedge with the DUT idle (or about to be idle on the coming edge when
  // hold_start is used); leaves the caller at the negedge of the first IDLE cycle after the job.
  task automatic run_job(input string tag, input int stall, input bit hold_start);
    longint pre [0:KA];
    int cyc;
    int rd_cnt;
    pre[0] = 0;
    for (int i = 0; i < KA; i++) pre[i+1] = pre[i] + longint'(a_g_mem[i]) * longint'(a_e_mem[i]);
    a_start_valid = 1'b1;
    a_res_ready   = (stall == 0);
    @(posedge clk);
    cyc = 0;
    rd_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!hold_start) a_start_valid = 1'b0;
      if (a_rd_en) begin
        check_val({tag, " rd_addr"}, a_rd_addr, rd_cnt);
        rd_cnt++;
      end
      if (cyc >= 3 + LA && cyc <= 3 + LA + KA)
        check_val({tag, " mac_partial"}, a_mac_o, pre[cyc-3-LA]);
      if (!a_res_valid) begin
        check_val({tag, " start_ready_busy"}, a_start_ready, 0);
        check_val({tag, " busy"}, a_busy, 1);
      end
    end while (!a_res_valid && cyc < 40);
    check_val({tag, " res_valid_cycle"}, cyc, KA + LA + 4);
    check_val({tag, " rd_pulses"}, rd_cnt, KA);
    check_val({tag, " res_data"}, a_res_data, pre[KA]);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_val({tag, " stall_valid"}, a_res_valid, 1);
      check_val({tag, " stall_data"}, a_res_data, pre[KA]);
      check_val({tag, " stall_rd_en"}, a_rd_en, 0);
    end
    a_res_ready = 1'b1;
    @(negedge clk);
    check_val({tag, " res_valid_drop"}, a_res_valid, 0);
    check_val({tag, " start_ready_back"}, a_start_ready, 1);
    if (stall == 0) check_val({tag, " start_ready_cycle"}, cyc + 1, KA + LA + 5);
    $display("job %s: result=%0d expected=%0d latency=%0d stall=%0d", tag, a_res_data, pre[KA], cyc, stall);
  endtask

  task automatic load_a(input int g0, input int g1, input int g2, input int e0, input int e1, input int e2);
    a_g_mem[0] = N'(g0); a_g_mem[1] = N'(g1); a_g_mem[2] = N'(g2); a_g_mem[3] = '0;
    a_e_mem[0] = N'(e0); a_e_mem[1] = N'(e1); a_e_mem[2] = N'(e2); a_e_mem[3] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rd_cnt;
    load_a(29, 74, -39, -38, -91, 47);
    b_g_mem[0] = -8'sd7; b_e_mem[0] = 8'sd9; b_g_mem[1] = '0; b_e_mem[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst mac_rst", a_mac_rst, 1);
    check_val("rst start_ready", a_start_ready, 1);
    check_val("rst busy", a_busy, 0);
    check_val("rst rd_en", a_rd_en, 0);
    check_val("rst rd_addr", a_rd_addr, 0);
    check_val("rst res_valid", a_res_valid, 0);
    check_val("rst res_data", a_res_data, 0);
    check_val("rst g_input", a_g_input, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst mac_rst", a_mac_rst, 0);

    run_job("basic", 0, 1'b0);
    run_job("backpressure", 10, 1'b0);

    // start_valid held through a job and into the next IDLE cycle
    run_job("busy1", 0, 1'b1);
    load_a(-5, 100, 3, 17, -2, -128);
    run_job("busy2", 0, 1'b0);

    load_a(-128, -128, -128, -128, -128, -128);
    run_job("extreme", 0, 1'b0);

    // reset in ISSUE at idx=1
    load_a(29, 74, -39, -38, -91, 47);
    a_start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start_valid = 1'b0;
    cyc = 0;
    while (!(a_rd_en && a_rd_addr == 2'd1) && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_val("midrst reached_idx1", a_rd_addr, 1);
    rst = 1'b1;
    #1;
    check_val("midrst mac_rst", a_mac_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst busy", a_busy, 0);
    check_val("midrst start_ready", a_start_ready, 1);
    check_val("midrst res_valid", a_res_valid, 0);
    check_val("midrst g_input", a_g_input, 0);
    check_val("midrst e_input", a_e_input, 0);
    check_val("midrst rd_en", a_rd_en, 0);
    repeat (10) begin
      @(negedge clk);
      check_val("midrst no_result", a_res_valid, 0);
    end
    run_job("after_rst", 0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      load_a($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      run_job($sformatf("rand%0d", j), $urandom_range(0, 4), 1'b0);
    end

    // build B: K=1, MAC_LAT=2
    b_start_valid = 1'b1;
    @(posedge clk);
    cyc = 0;
    rd_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      b_start_valid = 1'b0;
      if (b_rd_en) begin
        check_val("k1 rd_addr", b_rd_addr, 0);
        rd_cnt++;
      end
    end while (!b_res_valid && cyc < 40);
    check_val("k1 res_valid_cycle", cyc, KB + LB + 4);
    check_val("k1 rd_pulses", rd_cnt, 1);
    check_val("k1 res_data", b_res_data, -63);
    @(negedge clk);
    check_val("k1 start_ready_back", b_start_ready, 1);
    $display("job k1: result=%0d expected=-63 latency=%0d", b_res_data, cyc);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
